serial_add_ctrl: RTL

//  Bit-serial add/subtract sequencer around one FULL_ADDER instance. It takes two

---
 rtl/serial_add_ctrl_pkg.sv | 23 ++
 rtl/serial_add_ctrl_fa.sv | 23 ++
 rtl/serial_add_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : serial_add_ctrl_pkg                                            |
// | Purpose  : Shared types for the bit-serial add/subtract sequencer:        |
// |            FSM state encoding and a counter-width helper.                 |
// | Ports    : none (package)                                                 |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package serial_add_ctrl_pkg;

   typedef enum logic [1:0] {
      SA_IDLE = 2'b00,
      SA_RUN  = 2'b01,
      SA_DONE = 2'b10
   } sa_state_t;

   // Bit counter must be able to hold the value WIDTH itself.
   function automatic int sa_cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/serial_add_ctrl_fa.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : full_adder                                                     |
// | Purpose  : One-bit full adder used as the serial datapath.                |
// | Ports    : a, b, ci  - addend bits and carry in                           |
// |            s, co     - sum bit and carry out                              |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module full_adder
   import serial_add_ctrl_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : serial_add_ctrl                                                |
// | Purpose  : Bit-serial add/subtract sequencer. Operands are captured on    |
// |            START and fed LSB-first through one full adder, one bit per    |
// |            clock. After WIDTH cycles RESULT/CO/OVF are presented together |
// |            with a one-cycle DONE pulse.                                   |
// | Ports    : CLK, RST (sync, active-high)                                   |
// |            START, OP_SUB, A, B       - request and operands               |
// |            BUSY, DONE                - status                             |
// |            RESULT, CO, OVF           - sum/difference, carry, overflow    |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             OP_SUB,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] RESULT,
   output logic             CO,
   output logic             OVF
);

   localparam int CNT_W = sa_cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WIDTH - 1);

   sa_state_t        r_state;
   logic [WIDTH-1:0] r_asr;
   logic [WIDTH-1:0] r_bsr;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;

   logic             w_s;
   logic             w_c;

   full_adder u_fa (
      .a  (r_asr[0]),
      .b  (r_bsr[0]),
      .ci (r_carry),
      .s  (w_s),
      .co (w_c)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= SA_IDLE;
         r_asr   <= '0;
         r_bsr   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
         RESULT  <= '0;
         CO      <= 1'b0;
         OVF     <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (r_state)
            SA_IDLE, SA_DONE: begin
               if (START) begin
                  // Subtraction is A + ~B + 1: the +1 rides in as the initial carry.
                  r_asr   <= A;
                  r_bsr   <= OP_SUB ? ~B : B;
                  r_carry <= OP_SUB;
                  r_cnt   <= '0;
                  RESULT  <= '0;
                  CO      <= 1'b0;
                  OVF     <= 1'b0;
                  BUSY    <= 1'b1;
                  r_state <= SA_RUN;
               end else begin
                  r_state <= SA_IDLE;
               end
            end
            SA_RUN: begin
               RESULT  <= {w_s, RESULT[WIDTH-1:1]};
               r_carry <= w_c;
               r_asr   <= r_asr >> 1;
               r_bsr   <= r_bsr >> 1;
               r_cnt   <= r_cnt + 1'b1;
               if (r_cnt == c_last_cnt) begin
                  // On the MSB bit r_carry is the carry into the MSB, so the
                  // signed overflow is available in the same edge.
                  CO      <= w_c;
                  OVF     <= r_carry ^ w_c;
                  DONE    <= 1'b1;
                  BUSY    <= 1'b0;
                  r_state <= SA_DONE;
               end
            end
            default: begin
               BUSY    <= 1'b0;
               r_state <= SA_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
